bcd_time_counter: RTL
=====================

# bcd_time_counter

Parametrised BCD time-of-day counter (hh:mm:ss) with internal seconds prescaler, 12/24-hour mode, synchronous time load with range checking, and day-rollover pulse. Successor to the fixed 24-hour six-digit counter. Sits between the system clock and the 7-segment display/scan logic; all digit outputs drive the display path directly.

## Interface
Parameters:
- CLK_PER_SEC, 1, clk cycles per one-second advance; must be ≥1; 1 = advance every enabled cycle (simulation)
- HOUR_12, 0, 0 = 24-hour (00..23), 1 = 12-hour (12,01..11 with pm flag)

Ports:
- clk  in  1  global clock, rising edge
- rst  in  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high
- run  in  1  1 = prescaler and time advance; 0 = freeze all state
- load  in  1  synchronous time load strobe
- ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0  in  4 each  BCD load value
- ld_pm  in  1  pm flag load value (ignored when HOUR_12=0)
- hour1, hour0, min1, min0, sec1, sec0  out  4 each  BCD time digits, registered
- pm  out  1  pm flag, registered; constant 0 when HOUR_12=0
- sec_tick  out  1  one-cycle pulse on each second advance
- day_pulse  out  1  one-cycle pulse on day rollover
- load_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset values: 24h mode 00:00:00; 12h mode 12:00:00, pm=0; prescaler=0; sec_tick, day_pulse, load_err=0.
- Prescaler counts 0..CLK_PER_SEC-1 while run=1; at terminal count wraps to 0 and the time advances one second on that same edge; sec_tick asserted that cycle.
- Advance chain: sec0 9→0 carries to sec1; sec1:sec0 59→00 carries to minutes; min 59→00 carries to hours.
- 24h: hours 23→00 on carry, day_pulse asserted.
- 12h: hours 11→12 toggles pm; 12→01 no toggle; day_pulse when 11:59:59 pm→12:00:00 am.
- Load (priority over advance): valid when every digit ≤9, sec1≤5, min1≤5, hour in range (24h: 00..23; 12h: 01..12). Valid → all digits/pm take load values, prescaler cleared to 0, no sec_tick that cycle. Invalid → state unchanged, prescaler unchanged, load_err pulse, advance still occurs if due.
- load acts regardless of run.
- run=0: prescaler and time hold; sec_tick/day_pulse stay 0.

## Timing
- All outputs registered; tick-cycle edge updates digits, sec_tick, day_pulse together (latency 1 from terminal prescaler count).
- load sampled at edge N; new digits visible after edge N; next advance exactly CLK_PER_SEC run-cycles later.
- Simultaneous load and terminal count: load wins, prescaler restarts at 0.
- Reset mid-count: all state to reset values immediately, independent of clk.
- Pulses never exceed one cycle; day_pulse implies sec_tick same cycle.

## Configuration
- TIME_COUNTER_ALARM_EN defined: adds inputs alarm_en (1), al_hour1, al_hour0, al_min1, al_min0 (4 each), al_pm (1) and output alarm (1, reset 0). alarm pulses one cycle on the advance that makes time equal al hh:mm:00 (and pm match in 12h mode) while alarm_en=1; a load to a matching time does not fire alarm.
- Undefined: no alarm ports, no compare logic.

## Structure
- Shared package/include: BCD_BIT_WIDTH, BCD_ZERO, BCD_NINE, BCD_FIVE, ENABLED/DISABLED, hour limit constants for both modes.
- One sub-module: bcd_digit — single BCD digit with increment enable, programmable wrap value, synchronous load, carry out; six instances, hour pair wrap driven by mode logic.

## Test plan
- Reset, CLK_PER_SEC=4, run=1 for 16 clk → sec_tick every 4th cycle, time 00:00:04.
- Load 23:59:58 (24h), run 2 s → 23:59:59 then 00:00:00 with day_pulse and sec_tick on same cycle.
- HOUR_12=1: load 11:59:59 pm=0 → next tick 12:00:00 pm=1, no day_pulse; load 11:59:59 pm=1 → 12:00:00 pm=0 with day_pulse; 12:59:59 → 01:00:00 pm unchanged.
- Load 24:00:00 in 24h or sec 6A → load_err pulse, time unchanged; load coincident with terminal count → load value shown, next tick CLK_PER_SEC cycles later.
- run=0 for 10 cycles mid-count → digits and prescaler frozen; assert rst mid-count → outputs 00:00:00 asynchronously.
- With TIME_COUNTER_ALARM_EN, alarm 07:30, load 07:29:59 → alarm pulses once at 07:30:00; alarm_en=0 → no pulse.

Source files
------------

// File: rtl/bcd_time_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_time_counter_pkg
// Shared constants and helpers for the BCD time-of-day counter:
//   - BCD digit width, type and digit constants
//   - enable/disable constants
//   - hour limits for 24-hour and 12-hour modes
//   - bcd_step : one increment step of a BCD digit with programmable wrap
//   - time_ok  : range check applied to a time load request
// -----------------------------------------------------------------------------
package bcd_time_counter_pkg;

    localparam int BCD_BIT_WIDTH = 4;
    typedef logic [BCD_BIT_WIDTH-1:0] bcd_t;

    localparam bcd_t BCD_ZERO  = 4'd0;
    localparam bcd_t BCD_ONE   = 4'd1;
    localparam bcd_t BCD_TWO   = 4'd2;
    localparam bcd_t BCD_THREE = 4'd3;
    localparam bcd_t BCD_FIVE  = 4'd5;
    localparam bcd_t BCD_NINE  = 4'd9;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    localparam logic [7:0] HOUR24_MAX = 8'd23;
    localparam logic [7:0] HOUR12_MIN = 8'd1;
    localparam logic [7:0] HOUR12_MAX = 8'd12;

    // Next value of a digit: hold, wrap from max_v to min_v, or count up.
    function automatic bcd_t bcd_step(bcd_t cur, logic inc, bcd_t max_v, bcd_t min_v);
        bcd_t nxt;
        if (!inc) begin
            nxt = cur;
        end else if (cur == max_v) begin
            nxt = min_v;
        end else begin
            nxt = cur + BCD_ONE;
        end
        return nxt;
    endfunction

    // True when the six load digits form a legal time for the selected mode.
    function automatic logic time_ok(bcd_t h1, bcd_t h0, bcd_t m1, bcd_t m0,
                                     bcd_t s1, bcd_t s0, logic mode12);
        logic [7:0] hbin;
        logic       ok;
        hbin = ({4'd0, h1} * 8'd10) + {4'd0, h0};
        ok   = (h1 <= BCD_NINE) && (h0 <= BCD_NINE) && (m1 <= BCD_FIVE) &&
               (m0 <= BCD_NINE) && (s1 <= BCD_FIVE) && (s0 <= BCD_NINE);
        if (mode12) begin
            ok = ok && (hbin >= HOUR12_MIN) && (hbin <= HOUR12_MAX);
        end else begin
            ok = ok && (hbin <= HOUR24_MAX);
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_time_counter_if
// Control, load and display signals of the time counter.
//   master : drives run/load/load values, observes digits and pulses
//   slave  : the counter itself
// Optional alarm signals exist only when TIME_COUNTER_ALARM_EN is defined.
// -----------------------------------------------------------------------------
interface bcd_time_counter_if;
    import bcd_time_counter_pkg::*;

    logic run;
    logic load;
    bcd_t ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0;
    logic ld_pm;
    bcd_t hour1, hour0, min1, min0, sec1, sec0;
    logic pm;
    logic sec_tick;
    logic day_pulse;
    logic load_err;
`ifdef TIME_COUNTER_ALARM_EN
    logic alarm_en;
    bcd_t al_hour1, al_hour0, al_min1, al_min0;
    logic al_pm;
    logic alarm;
`endif

    modport master (
`ifdef TIME_COUNTER_ALARM_EN
        output alarm_en, al_hour1, al_hour0, al_min1, al_min0, al_pm,
        input  alarm,
`endif
        output run, load, ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0, ld_pm,
        input  hour1, hour0, min1, min0, sec1, sec0, pm, sec_tick, day_pulse, load_err
    );

    modport slave (
`ifdef TIME_COUNTER_ALARM_EN
        input  alarm_en, al_hour1, al_hour0, al_min1, al_min0, al_pm,
        output alarm,
`endif
        input  run, load, ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0, ld_pm,
        output hour1, hour0, min1, min0, sec1, sec0, pm, sec_tick, day_pulse, load_err
    );

endinterface

// File: rtl/bcd_time_counter_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One registered BCD digit.
//   inc_i    : count one step this cycle
//   max_i    : value after which the digit wraps
//   min_i    : value the digit wraps to
//   load_i   : synchronous load of ld_val_i (wins over inc_i)
//   q_o      : current digit
//   carry_o  : digit wraps this cycle (increment into the next digit)
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_time_counter_pkg::*;
#(
    parameter bcd_t RST_VAL = BCD_ZERO
)(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  bcd_t max_i,
    input  bcd_t min_i,
    input  logic load_i,
    input  bcd_t ld_val_i,
    output bcd_t q_o,
    output logic carry_o
);

    bcd_t digit_q;
    bcd_t digit_d;

    // Next digit value: load, else one counting step.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = ld_val_i;
        end else begin
            digit_d = bcd_step(digit_q, inc_i, max_i, min_i);
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= RST_VAL;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q_o     = digit_q;
    assign carry_o = inc_i && (digit_q == max_i);

endmodule

// File: rtl/bcd_time_counter.sv
// -----------------------------------------------------------------------------
// bcd_time_counter
// hh:mm:ss BCD time-of-day counter with seconds prescaler, 12/24-hour mode,
// range-checked synchronous load and day-rollover pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bcd_time_counter_if.slave (run, load + load values in;
//              digits, pm, sec_tick, day_pulse, load_err out)
// Parameters: CLK_PER_SEC (cycles per second, >=1), HOUR_12 (0=24h, 1=12h).
// Optional feature macro: TIME_COUNTER_ALARM_EN adds an hh:mm alarm.
// -----------------------------------------------------------------------------
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int CLK_PER_SEC = 1,
    parameter int HOUR_12     = 0
)(
    input logic               clk,
    input logic               rst,
    bcd_time_counter_if.slave bus
);

    localparam int              PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [PW-1:0]   PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic            MODE12     = (HOUR_12 != 0) ? ENABLED : DISABLED;
    localparam bcd_t            H1_RST     = MODE12 ? BCD_ONE : BCD_ZERO;
    localparam bcd_t            H0_RST     = MODE12 ? BCD_TWO : BCD_ZERO;

    logic [PW-1:0] presc_q, presc_d;
    logic          pm_q, pm_d;
    logic          sec_tick_q, day_pulse_q, load_err_q;

    logic ld_ok_s, load_go_s, tick_s, adv_s, eleven_s, day_s;
    bcd_t sec0_s, sec1_s, min0_s, min1_s, hour0_s, hour1_s;
    logic sec0_c_s, sec1_c_s, min0_c_s, min1_c_s, hour0_c_s, hour1_c_s;
    bcd_t h0_max_s, h0_min_s, h1_max_s;

    assign ld_ok_s   = time_ok(bus.ld_hour1, bus.ld_hour0, bus.ld_min1, bus.ld_min0,
                               bus.ld_sec1, bus.ld_sec0, MODE12);
    assign load_go_s = bus.load && ld_ok_s;
    assign tick_s    = bus.run && (presc_q == PRESC_LAST);
    // A valid load suppresses the advance that would otherwise happen this edge.
    assign adv_s     = tick_s && !load_go_s;
    assign eleven_s  = (hour1_s == BCD_ONE) && (hour0_s == BCD_ONE);

    // Hour digit wrap limits. 12h runs 12,01..11: hour0 wraps 2->1 in the teens.
    always_comb begin
        h0_max_s = BCD_NINE;
        h0_min_s = BCD_ZERO;
        h1_max_s = BCD_TWO;
        if (MODE12) begin
            h1_max_s = BCD_ONE;
            if (hour1_s == BCD_ONE) begin
                h0_max_s = BCD_TWO;
                h0_min_s = BCD_ONE;
            end else begin
                h0_max_s = BCD_NINE;
                h0_min_s = BCD_ZERO;
            end
        end else begin
            h1_max_s = BCD_TWO;
            h0_min_s = BCD_ZERO;
            h0_max_s = (hour1_s == BCD_TWO) ? BCD_THREE : BCD_NINE;
        end
    end

    bcd_digit #(.RST_VAL(BCD_ZERO)) u_sec0 (.clk(clk), .rst(rst), .inc_i(adv_s),
        .max_i(BCD_NINE), .min_i(BCD_ZERO), .load_i(load_go_s), .ld_val_i(bus.ld_sec0),
        .q_o(sec0_s), .carry_o(sec0_c_s));
    bcd_digit #(.RST_VAL(BCD_ZERO)) u_sec1 (.clk(clk), .rst(rst), .inc_i(sec0_c_s),
        .max_i(BCD_FIVE), .min_i(BCD_ZERO), .load_i(load_go_s), .ld_val_i(bus.ld_sec1),
        .q_o(sec1_s), .carry_o(sec1_c_s));
    bcd_digit #(.RST_VAL(BCD_ZERO)) u_min0 (.clk(clk), .rst(rst), .inc_i(sec1_c_s),
        .max_i(BCD_NINE), .min_i(BCD_ZERO), .load_i(load_go_s), .ld_val_i(bus.ld_min0),
        .q_o(min0_s), .carry_o(min0_c_s));
    bcd_digit #(.RST_VAL(BCD_ZERO)) u_min1 (.clk(clk), .rst(rst), .inc_i(min0_c_s),
        .max_i(BCD_FIVE), .min_i(BCD_ZERO), .load_i(load_go_s), .ld_val_i(bus.ld_min1),
        .q_o(min1_s), .carry_o(min1_c_s));
    bcd_digit #(.RST_VAL(H0_RST)) u_hour0 (.clk(clk), .rst(rst), .inc_i(min1_c_s),
        .max_i(h0_max_s), .min_i(h0_min_s), .load_i(load_go_s), .ld_val_i(bus.ld_hour0),
        .q_o(hour0_s), .carry_o(hour0_c_s));
    bcd_digit #(.RST_VAL(H1_RST)) u_hour1 (.clk(clk), .rst(rst), .inc_i(hour0_c_s),
        .max_i(h1_max_s), .min_i(BCD_ZERO), .load_i(load_go_s), .ld_val_i(bus.ld_hour1),
        .q_o(hour1_s), .carry_o(hour1_c_s));

    // Prescaler next state: cleared by a valid load, wraps at terminal count.
    always_comb begin
        presc_d = presc_q;
        if (load_go_s) begin
            presc_d = PRESC_ZERO;
        end else if (tick_s) begin
            presc_d = PRESC_ZERO;
        end else if (bus.run) begin
            presc_d = presc_q + PRESC_ONE;
        end else begin
            presc_d = presc_q;
        end
    end

    // pm flag and day rollover: in 12h the flag flips on 11->12, the day ends at 11 pm -> 12 am.
    always_comb begin
        pm_d  = pm_q;
        day_s = DISABLED;
        if (!MODE12) begin
            pm_d  = DISABLED;
            day_s = hour1_c_s;
        end else if (load_go_s) begin
            pm_d  = bus.ld_pm;
            day_s = DISABLED;
        end else if (min1_c_s && eleven_s) begin
            pm_d  = ~pm_q;
            day_s = pm_q;
        end else begin
            pm_d  = pm_q;
            day_s = DISABLED;
        end
    end

    // Prescaler, pm flag and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= PRESC_ZERO;
            pm_q        <= DISABLED;
            sec_tick_q  <= DISABLED;
            day_pulse_q <= DISABLED;
            load_err_q  <= DISABLED;
        end else begin
            presc_q     <= presc_d;
            pm_q        <= pm_d;
            sec_tick_q  <= adv_s;
            day_pulse_q <= day_s;
            load_err_q  <= bus.load && !ld_ok_s;
        end
    end

`ifdef TIME_COUNTER_ALARM_EN
    logic alarm_q, alarm_d;
    bcd_t s0_nx_s, s1_nx_s, m0_nx_s, m1_nx_s, h0_nx_s, h1_nx_s;

    // Time after this edge's advance; the alarm compares against it so it lines up with the digits.
    assign s0_nx_s = bcd_step(sec0_s, adv_s, BCD_NINE, BCD_ZERO);
    assign s1_nx_s = bcd_step(sec1_s, sec0_c_s, BCD_FIVE, BCD_ZERO);
    assign m0_nx_s = bcd_step(min0_s, sec1_c_s, BCD_NINE, BCD_ZERO);
    assign m1_nx_s = bcd_step(min1_s, min0_c_s, BCD_FIVE, BCD_ZERO);
    assign h0_nx_s = bcd_step(hour0_s, min1_c_s, h0_max_s, h0_min_s);
    assign h1_nx_s = bcd_step(hour1_s, hour0_c_s, h1_max_s, BCD_ZERO);

    // Alarm fires only on an advance, never on a load.
    always_comb begin
        alarm_d = DISABLED;
        if (adv_s && bus.alarm_en &&
            (s0_nx_s == BCD_ZERO) && (s1_nx_s == BCD_ZERO) &&
            (m0_nx_s == bus.al_min0) && (m1_nx_s == bus.al_min1) &&
            (h0_nx_s == bus.al_hour0) && (h1_nx_s == bus.al_hour1) &&
            (!MODE12 || (pm_d == bus.al_pm))) begin
            alarm_d = ENABLED;
        end else begin
            alarm_d = DISABLED;
        end
    end

    // Alarm pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= DISABLED;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign bus.alarm = alarm_q;
`endif

    assign bus.sec0      = sec0_s;
    assign bus.sec1      = sec1_s;
    assign bus.min0      = min0_s;
    assign bus.min1      = min1_s;
    assign bus.hour0     = hour0_s;
    assign bus.hour1     = hour1_s;
    assign bus.pm        = pm_q;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.day_pulse = day_pulse_q;
    assign bus.load_err  = load_err_q;

endmodule
